// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, register-file and execute-side signals of the
// decode stage. The slave modport is the decode stage's own view; the
// master modport is the surrounding pipeline's view.
interface decode_stage_if #(
  parameter int REG_WIDTH     = 8,
  parameter int REG_DIR_WIDTH = 3,
  parameter int PC_WIDTH      = 8,
  parameter int CNT_WIDTH     = 16
);
  // Fetch side
  logic                     if_valid;
  logic [15:0]              if_instr;
  logic [PC_WIDTH-1:0]      if_pc;
  logic                     stall;
  logic                     id_jump;
  logic [PC_WIDTH-1:0]      id_jump_target;

  // Register-file read ports
  logic [REG_DIR_WIDTH-1:0] readr1;
  logic [REG_DIR_WIDTH-1:0] readr2;
  logic [REG_WIDTH-1:0]     readd1;
  logic [REG_WIDTH-1:0]     readd2;

  // Execute side
  logic                     ex_flush;
  logic                     ex_valid;
  logic                     ex_alu_src;
  logic                     ex_mem_read;
  logic                     ex_mem_write;
  logic                     ex_reg_write;
  logic                     ex_branch;
  logic [2:0]               ex_alu_op;
  logic [REG_DIR_WIDTH-1:0] ex_rs;
  logic [REG_DIR_WIDTH-1:0] ex_rt;
  logic [REG_DIR_WIDTH-1:0] ex_dest;
  logic [REG_WIDTH-1:0]     ex_rs_data;
  logic [REG_WIDTH-1:0]     ex_rt_data;
  logic [REG_WIDTH-1:0]     ex_imm;
  logic [PC_WIDTH-1:0]      ex_pc;

  // Status
  logic [CNT_WIDTH-1:0]     stall_count;

  modport slave (
    input  if_valid, if_instr, if_pc, ex_flush, readd1, readd2,
    output stall, id_jump, id_jump_target, readr1, readr2,
    output ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
    output ex_branch, ex_alu_op, ex_rs, ex_rt, ex_dest,
    output ex_rs_data, ex_rt_data, ex_imm, ex_pc, stall_count
  );

  modport master (
    output if_valid, if_instr, if_pc, ex_flush, readd1, readd2,
    input  stall, id_jump, id_jump_target, readr1, readr2,
    input  ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
    input  ex_branch, ex_alu_op, ex_rs, ex_rt, ex_dest,
    input  ex_rs_data, ex_rt_data, ex_imm, ex_pc, stall_count
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: instruction-decode stage of the 8-bit MIPS-style core.
// Holds the IF/ID latch, drives register-file read addresses, decodes the
// instruction into the ID/EX latch, resolves jumps and honours EX flushes.
// Optional feature macro: DECODE_HAZARD_DETECT_EN enables load-use stall
// detection and the saturating stall counter; without it stall and
// stall_count are tied to 0 and software must pad loads with NOPs.
module decode_stage #(
  parameter int REG_WIDTH     = 8,
  parameter int REG_DIR_WIDTH = 3,
  parameter int PC_WIDTH      = 8,
  parameter int CNT_WIDTH     = 16
) (
  input logic            clk,
  input logic            rst,
  decode_stage_if.slave  bus
);

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_J     = 4'd5;

  typedef struct packed {
    logic                     valid;
    logic                     alu_src;
    logic                     mem_read;
    logic                     mem_write;
    logic                     reg_write;
    logic                     branch;
    logic [2:0]               alu_op;
    logic [REG_DIR_WIDTH-1:0] rs;
    logic [REG_DIR_WIDTH-1:0] rt;
    logic [REG_DIR_WIDTH-1:0] dest;
    logic [REG_WIDTH-1:0]     rs_data;
    logic [REG_WIDTH-1:0]     rt_data;
    logic [REG_WIDTH-1:0]     imm;
    logic [PC_WIDTH-1:0]      pc;
  } idex_t;

  // IF/ID latch
  logic                     ifid_valid;
  logic [15:0]              ifid_instr;
  logic [PC_WIDTH-1:0]      ifid_pc;

  // ID/EX latch and its next value
  idex_t                    idex_q;
  idex_t                    idex_d;

  // Instruction fields of the word held in IF/ID
  logic [3:0]               opcode;
  logic [REG_DIR_WIDTH-1:0] rs;
  logic [REG_DIR_WIDTH-1:0] rt;
  logic [REG_DIR_WIDTH-1:0] rd;
  logic [2:0]               funct;
  logic [5:0]               imm6;

  logic                     stall;
  logic                     jump_taken;

  assign opcode = ifid_instr[15:12];
  assign rs     = ifid_instr[11:9];
  assign rt     = ifid_instr[8:6];
  assign rd     = ifid_instr[5:3];
  assign funct  = ifid_instr[2:0];
  assign imm6   = ifid_instr[5:0];

  // A flush from EX kills the jump: its redirect must not override the branch.
  assign jump_taken = ifid_valid && (opcode == OP_J) && !bus.ex_flush;

  // Decode the IF/ID word into the control and operand bundle for ID/EX.
  always_comb begin
    // NOTE: every field gets a default before the case so no latch is inferred.
    idex_d = '0;
    if (ifid_valid) begin
      idex_d.valid   = 1'b1;
      idex_d.rs      = rs;
      idex_d.rt      = rt;
      idex_d.rs_data = bus.readd1;
      idex_d.rt_data = bus.readd2;
      idex_d.imm     = {{(REG_WIDTH-6){imm6[5]}}, imm6};
      idex_d.pc      = ifid_pc;
      case (opcode)
        OP_RTYPE: begin
          idex_d.alu_op    = funct;
          idex_d.reg_write = 1'b1;
          idex_d.dest      = rd;
        end
        OP_ADDI: begin
          idex_d.alu_src   = 1'b1;
          idex_d.reg_write = 1'b1;
          idex_d.dest      = rt;
        end
        OP_LW: begin
          idex_d.alu_src   = 1'b1;
          idex_d.mem_read  = 1'b1;
          idex_d.reg_write = 1'b1;
          idex_d.dest      = rt;
        end
        OP_SW: begin
          idex_d.alu_src   = 1'b1;
          idex_d.mem_write = 1'b1;
        end
        OP_BEQ: begin
          idex_d.alu_op    = 3'd1;
          idex_d.branch    = 1'b1;
        end
        default: begin
          // j and opcodes 6-15 travel down the pipe as NOPs.
        end
      endcase
      // r0 is hard-wired zero, so a write to it is dropped here.
      if (idex_d.dest == '0) begin
        idex_d.reg_write = 1'b0;
      end
    end
  end

`ifdef DECODE_HAZARD_DETECT_EN
  logic                 use_rs;
  logic                 use_rt;
  logic                 hazard;
  logic [CNT_WIDTH-1:0] stall_cnt;

  // Detect a load in EX whose destination feeds a source used by IF/ID.
  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (opcode)
      OP_RTYPE, OP_SW, OP_BEQ: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        use_rs = 1'b1;
      end
      default: begin
        use_rs = 1'b0;
        use_rt = 1'b0;
      end
    endcase
    hazard = ifid_valid && idex_q.valid && idex_q.mem_read &&
             (idex_q.dest != '0) &&
             ((use_rs && (idex_q.dest == rs)) || (use_rt && (idex_q.dest == rt)));
  end

  // A flush empties both latches anyway, so it suppresses the stall.
  assign stall = hazard && !bus.ex_flush;

  // Count stall cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.stall_count = stall_cnt;
`else
  assign stall           = 1'b0;
  assign bus.stall_count = '0;
`endif

  // IF/ID latch: cleared by flush, held on stall, squashed after a jump.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use <= so every register samples pre-edge values.
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (bus.ex_flush) begin
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_valid <= bus.if_valid && !jump_taken;
      ifid_instr <= bus.if_instr;
      ifid_pc    <= bus.if_pc;
    end
  end

  // ID/EX latch: a bubble on flush or stall, otherwise the decoded IF/ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
    end else if (bus.ex_flush || stall) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  // Combinational outputs toward fetch and the register file
  assign bus.stall          = stall;
  assign bus.readr1         = rs;
  assign bus.readr2         = rt;
  assign bus.id_jump        = jump_taken;
  assign bus.id_jump_target = ifid_instr[PC_WIDTH-1:0];

  // Registered outputs toward EX
  assign bus.ex_valid       = idex_q.valid;
  assign bus.ex_alu_src     = idex_q.alu_src;
  assign bus.ex_mem_read    = idex_q.mem_read;
  assign bus.ex_mem_write   = idex_q.mem_write;
  assign bus.ex_reg_write   = idex_q.reg_write;
  assign bus.ex_branch      = idex_q.branch;
  assign bus.ex_alu_op      = idex_q.alu_op;
  assign bus.ex_rs          = idex_q.rs;
  assign bus.ex_rt          = idex_q.rt;
  assign bus.ex_dest        = idex_q.dest;
  assign bus.ex_rs_data     = idex_q.rs_data;
  assign bus.ex_rt_data     = idex_q.rt_data;
  assign bus.ex_imm         = idex_q.imm;
  assign bus.ex_pc          = idex_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage. Stimulus
// pushes the hand-computed ID/EX contents of each instruction that should
// reach EX; a monitor pops and compares whenever ex_valid is high.
// Expectations follow DECODE_HAZARD_DETECT_EN when it is defined.
module tb_decode_stage;

`ifdef DECODE_HAZARD_DETECT_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  typedef struct packed {
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic [2:0] alu_op;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] dest;
    logic [7:0] rs_data;
    logic [7:0] rt_data;
    logic [7:0] imm;
    logic [7:0] pc;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file contents seen through the read ports
  function automatic logic [7:0] rf(input logic [2:0] a);
    case (a)
      3'd1:    rf = 8'h05;
      3'd2:    rf = 8'h07;
      3'd3:    rf = 8'h13;
      3'd4:    rf = 8'h24;
      3'd5:    rf = 8'h35;
      3'd6:    rf = 8'h46;
      3'd7:    rf = 8'h57;
      default: rf = 8'h00;
    endcase
  endfunction

  assign bus.readd1 = rf(bus.readr1);
  assign bus.readd2 = rf(bus.readr2);

  function automatic exp_t mk(input logic s, mr, mw, rw, br,
                              input logic [2:0] op, a, b, d,
                              input logic [7:0] da, db, im, pc);
    mk = '{s, mr, mw, rw, br, op, a, b, d, da, db, im, pc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [7:0] pc);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every valid ID/EX entry must match the oldest expectation
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (!rst && bus.ex_valid) begin
      act = mk(bus.ex_alu_src, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write,
               bus.ex_branch, bus.ex_alu_op, bus.ex_rs, bus.ex_rt, bus.ex_dest,
               bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_pc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL idex_unexpected actual=%0h pc=%0h", act, bus.ex_pc);
      end else begin
        e = exp_q.pop_front();
        check("idex", act, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.ex_flush = 1'b0;
    drive(1'b0, 16'h0000, 8'h00);

    // Reset state
    repeat (2) tick();
    check("rst_stall",       bus.stall,       0);
    check("rst_id_jump",     bus.id_jump,     0);
    check("rst_readr1",      bus.readr1,      0);
    check("rst_readr2",      bus.readr2,      0);
    check("rst_stall_count", bus.stall_count, 0);
    check("rst_ex_valid",    bus.ex_valid,    0);
    rst = 1'b0;

    // add r3,r1,r2
    drive(1'b1, 16'h0298, 8'h10);
    tick();
    exp_q.push_back(mk(0,0,0,1,0, 3'd0, 3'd1,3'd2,3'd3, 8'h05,8'h07, 8'h18, 8'h10));
    check("add_readr1", bus.readr1, 1);
    check("add_readr2", bus.readr2, 2);
    drive(1'b0, 16'h0000, 8'h00);
    repeat (2) tick();

    // lw r2,0(r1) then add r4,r2,r1: load-use
    drive(1'b1, 16'h2280, 8'h11);
    tick();
    exp_q.push_back(mk(1,1,0,1,0, 3'd0, 3'd1,3'd2,3'd2, 8'h05,8'h07, 8'h00, 8'h11));
    drive(1'b1, 16'h0460, 8'h12);
    tick();
    exp_q.push_back(mk(0,0,0,1,0, 3'd0, 3'd2,3'd1,3'd4, 8'h07,8'h05, 8'hE0, 8'h12));
    check("lu_stall_on",      bus.stall,       HAZ);
    check("lu_count_before",  bus.stall_count, 0);
    drive(1'b0, 16'h0000, 8'h00);
    tick();
    check("lu_stall_off",     bus.stall,       0);
    check("lu_count_after",   bus.stall_count, HAZ ? 1 : 0);
    check("lu_bubble_valid",  bus.ex_valid,    HAZ ? 0 : 1);
    repeat (3) tick();

    // addi r5,r1,-3 / addi r0,r1,1 / sw r3,2(r4) / beq r1,r2,-1 / slt r7,r6,r5
    drive(1'b1, 16'h137D, 8'h20);
    tick();
    exp_q.push_back(mk(1,0,0,1,0, 3'd0, 3'd1,3'd5,3'd5, 8'h05,8'h35, 8'hFD, 8'h20));
    drive(1'b1, 16'h1201, 8'h21);
    tick();
    exp_q.push_back(mk(1,0,0,0,0, 3'd0, 3'd1,3'd0,3'd0, 8'h05,8'h00, 8'h01, 8'h21));
    check("addi0_readr1", bus.readr1, 1);
    check("addi0_readr2", bus.readr2, 0);
    drive(1'b1, 16'h38C2, 8'h22);
    tick();
    exp_q.push_back(mk(1,0,1,0,0, 3'd0, 3'd4,3'd3,3'd0, 8'h24,8'h13, 8'h02, 8'h22));
    drive(1'b1, 16'h42BF, 8'h23);
    tick();
    exp_q.push_back(mk(0,0,0,0,1, 3'd1, 3'd1,3'd2,3'd0, 8'h05,8'h07, 8'hFF, 8'h23));
    drive(1'b1, 16'h0D7C, 8'h24);
    tick();
    exp_q.push_back(mk(0,0,0,1,0, 3'd4, 3'd6,3'd5,3'd7, 8'h46,8'h35, 8'hFC, 8'h24));
    check("stream_no_stall", bus.stall, 0);
    drive(1'b0, 16'h0000, 8'h00);
    repeat (2) tick();

    // j 0x42; the wrong-path add at 0x31 must never reach EX
    drive(1'b1, 16'h5042, 8'h30);
    tick();
    exp_q.push_back(mk(0,0,0,0,0, 3'd0, 3'd0,3'd1,3'd0, 8'h00,8'h05, 8'h02, 8'h30));
    check("j_id_jump", bus.id_jump,        1);
    check("j_target",  bus.id_jump_target, 8'h42);
    drive(1'b1, 16'h0298, 8'h31);
    tick();
    check("j_squash_jump", bus.id_jump, 0);
    drive(1'b1, 16'h1185, 8'h42);
    tick();
    exp_q.push_back(mk(1,0,0,1,0, 3'd0, 3'd0,3'd6,3'd6, 8'h00,8'h46, 8'h05, 8'h42));
    drive(1'b0, 16'h0000, 8'h00);
    repeat (2) tick();

    // ex_flush coinciding with a load-use stall
    drive(1'b1, 16'h22C0, 8'h50);
    tick();
    exp_q.push_back(mk(1,1,0,1,0, 3'd0, 3'd1,3'd3,3'd3, 8'h05,8'h13, 8'h00, 8'h50));
    drive(1'b1, 16'h06E8, 8'h51);
    tick();
    check("fl_stall_pre", bus.stall,       HAZ);
    check("fl_count_pre", bus.stall_count, HAZ ? 1 : 0);
    bus.ex_flush = 1'b1;
    drive(1'b1, 16'h0298, 8'h52);
    #1;
    check("fl_stall_masked", bus.stall, 0);
    tick();
    bus.ex_flush = 1'b0;
    drive(1'b0, 16'h0000, 8'h00);
    check("fl_ex_valid",   bus.ex_valid,    0);
    check("fl_count_hold", bus.stall_count, HAZ ? 1 : 0);
    tick();
    check("fl_ifid_clear", bus.ex_valid, 0);
    tick();

    // ex_flush coinciding with a jump
    drive(1'b1, 16'h5042, 8'h60);
    tick();
    bus.ex_flush = 1'b1;
    drive(1'b0, 16'h0000, 8'h00);
    #1;
    check("fl_jump_masked", bus.id_jump, 0);
    tick();
    bus.ex_flush = 1'b0;
    repeat (2) tick();

    // rst while a lw sits in ID/EX and the dependent add stalls
    drive(1'b1, 16'h2280, 8'h70);
    tick();
    exp_q.push_back(mk(1,1,0,1,0, 3'd0, 3'd1,3'd2,3'd2, 8'h05,8'h07, 8'h00, 8'h70));
    drive(1'b1, 16'h0460, 8'h71);
    tick();
    check("rm_stall_pre", bus.stall, HAZ);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rm_ex_valid",     bus.ex_valid,     0);
    check("rm_ex_mem_read",  bus.ex_mem_read,  0);
    check("rm_ex_reg_write", bus.ex_reg_write, 0);
    check("rm_ex_dest",      bus.ex_dest,      0);
    check("rm_ex_pc",        bus.ex_pc,        0);
    check("rm_stall",        bus.stall,        0);
    check("rm_stall_count",  bus.stall_count,  0);
    drive(1'b0, 16'h0000, 8'h00);
    tick();
    rst = 1'b0;
    drive(1'b1, 16'h0298, 8'h80);
    tick();
    exp_q.push_back(mk(0,0,0,1,0, 3'd0, 3'd1,3'd2,3'd3, 8'h05,8'h07, 8'h18, 8'h80));
    check("rm_accept_readr1", bus.readr1, 1);
    drive(1'b0, 16'h0000, 8'h00);
    repeat (3) tick();

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
